io_flag_controller: RTL and testbench
=====================================

// Module: io_flag_controller
// PURPOSE
// Sequences the keyboard/VGA io_interface for the Basic Computer CPU. Implements INPR, OUTR, FGI, FGO
// and IEN, and produces skip and interrupt requests. Synchronizes the keyboard-ready and VGA-done flags
// into the CPU clock domain. Buffers keystrokes in a small FIFO so bytes arriving while FGI=1 are not lost.
// PARAMETERS
// IN_FIFO_DEPTH  4      keystroke FIFO entries; power of two, >=2
// OUT_TIMEOUT    65535  CPU cycles in OUT_BUSY before FGO is forced to 1 and out_err pulses
// PORTS
// clock      in   1  CPU clock; all state is on its rising edge
// reset      in   1  asynchronous, active-low; clears all state
// kbd_data   in   8  keyboard_input_data; stable while kbd_flag is high
// kbd_flag   in   1  input_arrived_flag; asynchronous level, rising edge = new byte
// vga_done   in   1  output_went_flag; asynchronous level, rising edge = character displayed
// ac_low     in   8  AC[7:0]; sampled on cmd_out
// cmd_inp    in   1  1-cycle strobe: pop FIFO (INP)
// cmd_out    in   1  1-cycle strobe: load OUTR (OUT)
// cmd_ski    in   1  1-cycle strobe: skip if FGI
// cmd_sko    in   1  1-cycle strobe: skip if FGO
// cmd_ion    in   1  1-cycle strobe: IEN<=1
// cmd_iof    in   1  1-cycle strobe: IEN<=0
// int_ack    in   1  1-cycle strobe: CPU entered interrupt cycle; IEN<=0
// inpr       out  8  FIFO head (0x00 when empty)
// outr       out  8  OUTR register, drives outr_outdata
// outr_load  out  1  1-cycle pulse, the cycle after OUTR is written
// fgi        out  1  FIFO not empty
// fgo        out  1  output device ready
// ien        out  1  interrupt enable
// skip       out  1  registered skip result, 1-cycle pulse
// irq        out  1  ien & (fgi | fgo), registered
// kbd_drop   out  1  1-cycle pulse: byte arrived while FIFO full, byte discarded
// out_err    out  1  1-cycle pulse: OUT issued while FGO=0, or timeout expired
// BEHAVIOUR
// - Reset values: inpr=0, outr=0, FIFO empty, fgi=0, fgo=1, ien=0; skip, irq, outr_load, kbd_drop
//   and out_err are 0. Reset mid-operation discards FIFO contents and an in-flight OUT.
// - Synchronizers: kbd_flag and vga_done each pass 2 flops plus a rising-edge detect. An event is
//   acted on 3 cycles after the raw edge. kbd_data is captured on the kbd edge pulse.
// - FIFO push on kbd edge; pop on cmd_inp. Pointers are log2(IN_FIFO_DEPTH) bits and wrap around.
//   A count register of log2+1 bits provides full/empty.
// - Push and pop in the same cycle: both take effect, count unchanged. When full this is legal and
//   kbd_drop stays 0. When empty, the pop is ignored and the push proceeds.
// - Push when full with no pop: the byte is discarded and kbd_drop pulses. Pop when empty: no-op.
// - Output FSM states: IDLE (fgo=1), BUSY (fgo=0).
//   - IDLE + cmd_out: outr<=ac_low, go to BUSY, outr_load=1 next cycle.
//   - BUSY + vga_done edge: go to IDLE.
//   - BUSY + timeout counter reaching OUT_TIMEOUT: go to IDLE and pulse out_err.
//   - BUSY + cmd_out: ignored (outr unchanged) and out_err pulses.
//   - A vga_done edge in IDLE is ignored.
// - skip (1-cycle latency) reflects fgi/fgo before any same-cycle pop or OUT.
// - IEN: when iof/int_ack and ion are in the same cycle, clear wins.
// - irq is 1-cycle latency from the flags.
// - Simultaneous cmd strobes are each applied independently, following the rules above.
// STRUCTURE
// - Shared include bc_io_defs.vh: output FSM state encodings, BC_CHAR_W=8, IDLE value of FGO.
// - Sub-module io_sync_edge: 2-flop synchronizer plus rising-edge pulse, async active-low reset.
//   Instantiated twice (kbd_flag, vga_done).
// - FIFO, output FSM, timeout counter and IEN logic are inline.
// TESTING
// - Reset release -> fgo=1, fgi=0, ien=0, inpr=0x00, irq=0.
// - kbd_data=0x41, kbd_flag rises -> fgi=1 and inpr=0x41 by the 4th clock. cmd_inp -> fgi=0 next cycle.
// - 5 bytes 0x30..0x34 with no pops at depth 4 -> kbd_drop pulses once on 0x34.
//   4 pops return 0x30..0x33 in order.
// - ac_low=0x5A with cmd_out -> outr=0x5A, outr_load pulse, fgo=0. A 2nd cmd_out -> out_err pulse,
//   outr stays 0x5A. vga_done rises -> fgo=1 after 3 cycles.
// - cmd_ion, then a key arrives -> irq=1. int_ack -> ien=0 and irq=0 the following cycle.
//   cmd_ion together with cmd_iof -> ien=0.
// - OUT_TIMEOUT=8, cmd_out with no vga_done -> fgo=1 and out_err pulse 8 cycles later.
//   Reset asserted mid-BUSY -> fgo=1 immediately.

Source files
------------

// File: rtl/io_flag_controller_pkg.sv
// io_flag_controller_pkg: shared widths and output FSM encoding for the Basic Computer I/O block
package io_flag_controller_pkg;
  localparam int BC_CHAR_W = 8;
  localparam logic FGO_IDLE = 1'b1;
  typedef enum logic {OUT_IDLE = 1'b0, OUT_BUSY = 1'b1} out_state_t;
endpackage

// File: rtl/io_flag_controller_sync_edge.sv
// io_flag_controller_sync_edge: 2-flop synchronizer with rising-edge pulse for an asynchronous level
module io_flag_controller_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);
  logic [2:0] r_sh;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sh <= '0;
    else r_sh <= {r_sh[1:0], i_async};
  assign o_rise = r_sh[1] & ~r_sh[2];
endmodule

// File: rtl/io_flag_controller.sv
// io_flag_controller: INPR/OUTR/FGI/FGO/IEN sequencing for the Basic Computer keyboard/VGA interface,
// with a keystroke FIFO behind FGI and a timeout on the output handshake.
module io_flag_controller
  import io_flag_controller_pkg::*;
#(
  parameter int IN_FIFO_DEPTH = 4,
  parameter int OUT_TIMEOUT   = 65535
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [BC_CHAR_W-1:0] i_kbd_data,
  input  logic                 i_kbd_flag,
  input  logic                 i_vga_done,
  input  logic [BC_CHAR_W-1:0] i_ac_low,
  input  logic                 i_cmd_inp,
  input  logic                 i_cmd_out,
  input  logic                 i_cmd_ski,
  input  logic                 i_cmd_sko,
  input  logic                 i_cmd_ion,
  input  logic                 i_cmd_iof,
  input  logic                 i_int_ack,
  output logic [BC_CHAR_W-1:0] o_inpr,
  output logic [BC_CHAR_W-1:0] o_outr,
  output logic                 o_outr_load,
  output logic                 o_fgi,
  output logic                 o_fgo,
  output logic                 o_ien,
  output logic                 o_skip,
  output logic                 o_irq,
  output logic                 o_kbd_drop,
  output logic                 o_out_err
);
  localparam int AW = $clog2(IN_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(OUT_TIMEOUT + 1);
  logic                 w_kbd_rise, w_vga_rise;
  logic [BC_CHAR_W-1:0] r_mem [IN_FIFO_DEPTH];
  logic [AW-1:0]        r_wp, r_rp;
  logic [CW-1:0]        r_cnt;
  logic                 w_empty, w_full, w_pop, w_push, w_drop;
  out_state_t           r_state, w_state_nx;
  logic [TW-1:0]        r_tmo, w_tmo_nx;
  logic                 w_accept, w_err_nx;
  logic [BC_CHAR_W-1:0] r_outr;
  logic                 r_outr_load, r_ien, r_skip, r_irq, r_drop, r_err;

  io_flag_controller_sync_edge u_kbd_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_kbd_flag), .o_rise(w_kbd_rise)
  );
  io_flag_controller_sync_edge u_vga_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_vga_done), .o_rise(w_vga_rise)
  );

  // A pop frees a slot in the same cycle, so a push onto a full FIFO with a pop is not a drop.
  assign w_empty = r_cnt == '0;
  assign w_full  = r_cnt == CW'(IN_FIFO_DEPTH);
  assign w_pop   = i_cmd_inp & ~w_empty;
  assign w_push  = w_kbd_rise & (~w_full | w_pop);
  assign w_drop  = w_kbd_rise & w_full & ~w_pop;

  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp] <= i_kbd_data;

  always_comb begin
    w_state_nx = r_state;
    w_tmo_nx   = r_tmo;
    w_accept   = i_cmd_out & (r_state == OUT_IDLE);
    w_err_nx   = i_cmd_out & (r_state == OUT_BUSY);
    if (r_state == OUT_IDLE) begin
      if (i_cmd_out) begin
        w_state_nx = OUT_BUSY;
        w_tmo_nx   = '0;
      end
    end else if (w_vga_rise) w_state_nx = OUT_IDLE;
    else if (r_tmo == TW'(OUT_TIMEOUT - 1)) begin
      w_state_nx = OUT_IDLE;
      w_err_nx   = 1'b1;
    end else w_tmo_nx = r_tmo + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      r_state     <= OUT_IDLE;
      r_tmo       <= '0;
      r_outr      <= '0;
      r_outr_load <= 1'b0;
      r_ien       <= 1'b0;
      r_skip      <= 1'b0;
      r_irq       <= 1'b0;
      r_drop      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wp        <= r_wp + AW'(w_push);
      r_rp        <= r_rp + AW'(w_pop);
      r_cnt       <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_state     <= w_state_nx;
      r_tmo       <= w_tmo_nx;
      r_outr      <= w_accept ? i_ac_low : r_outr;
      r_outr_load <= w_accept;
      r_ien       <= (i_cmd_iof | i_int_ack) ? 1'b0 : (i_cmd_ion | r_ien);
      r_skip      <= (i_cmd_ski & ~w_empty) | (i_cmd_sko & o_fgo);
      r_irq       <= r_ien & (~w_empty | o_fgo);
      r_drop      <= w_drop;
      r_err       <= w_err_nx;
    end

  assign o_inpr      = w_empty ? '0 : r_mem[r_rp];
  assign o_outr      = r_outr;
  assign o_outr_load = r_outr_load;
  assign o_fgi       = ~w_empty;
  assign o_fgo       = (r_state == OUT_IDLE) ? FGO_IDLE : ~FGO_IDLE;
  assign o_ien       = r_ien;
  assign o_skip      = r_skip;
  assign o_irq       = r_irq;
  assign o_kbd_drop  = r_drop;
  assign o_out_err   = r_err;
endmodule

// File: tb/tb_io_flag_controller.sv
// tb_io_flag_controller: table vectors, directed corner sequences and randomized traffic against a
// queue-based reference model of the I/O flag controller.
module tb_io_flag_controller;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] kbd_data, ac_low;
  logic kbd_flag, vga_done;
  logic cmd_inp, cmd_out, cmd_ski, cmd_sko, cmd_ion, cmd_iof, int_ack;
  logic [7:0] o_inpr, o_outr;
  logic o_outr_load, o_fgi, o_fgo, o_ien, o_skip, o_irq, o_kbd_drop, o_out_err;

  io_flag_controller #(.IN_FIFO_DEPTH(DEPTH), .OUT_TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_kbd_data(kbd_data), .i_kbd_flag(kbd_flag),
    .i_vga_done(vga_done), .i_ac_low(ac_low), .i_cmd_inp(cmd_inp), .i_cmd_out(cmd_out),
    .i_cmd_ski(cmd_ski), .i_cmd_sko(cmd_sko), .i_cmd_ion(cmd_ion), .i_cmd_iof(cmd_iof),
    .i_int_ack(int_ack), .o_inpr(o_inpr), .o_outr(o_outr), .o_outr_load(o_outr_load),
    .o_fgi(o_fgi), .o_fgo(o_fgo), .o_ien(o_ien), .o_skip(o_skip), .o_irq(o_irq),
    .o_kbd_drop(o_kbd_drop), .o_out_err(o_out_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, drop_cnt = 0, cyc = 0;
  int kq[$], vq[$];
  logic [7:0] mq[$];
  logic [7:0] m_outr;
  bit kprev, vprev, m_busy, m_load, m_err, m_drop, m_skip, m_irq, m_ien;
  int m_t;

  typedef struct {int ion, iof, ack, ski, sko, e_ien, e_skip, e_irq;} vec_t;
  vec_t tbl[8];

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    kq.delete(); vq.delete(); mq.delete();
    kprev = 0; vprev = 0; m_busy = 0; m_t = 0; m_outr = 0;
    m_load = 0; m_err = 0; m_drop = 0; m_skip = 0; m_irq = 0; m_ien = 0;
  endtask

  // One rising clock edge of behaviour, evaluated from the inputs present at that edge.
  task automatic model_step();
    bit kev = 0, vev = 0;
    bit fgi = mq.size() != 0;
    bit fgo = !m_busy;
    while (kq.size() > 0 && kq[0] == cyc) begin kev = 1; void'(kq.pop_front()); end
    while (vq.size() > 0 && vq[0] == cyc) begin vev = 1; void'(vq.pop_front()); end
    if (kbd_flag && !kprev) kq.push_back(cyc + 2);
    if (vga_done && !vprev) vq.push_back(cyc + 2);
    kprev = kbd_flag; vprev = vga_done;
    m_skip = (cmd_ski && fgi) || (cmd_sko && fgo);
    m_irq = m_ien && (fgi || fgo);
    m_drop = 0;
    if (cmd_inp && fgi) void'(mq.pop_front());
    if (kev) begin
      if (mq.size() < DEPTH) mq.push_back(kbd_data);
      else m_drop = 1;
    end
    m_load = 0; m_err = 0;
    if (!m_busy) begin
      if (cmd_out) begin m_outr = ac_low; m_busy = 1; m_t = 0; m_load = 1; end
    end else begin
      if (cmd_out) m_err = 1;
      if (vev) m_busy = 0;
      else begin
        m_t++;
        if (m_t == TMO) begin m_busy = 0; m_err = 1; end
      end
    end
    if (cmd_iof || int_ack) m_ien = 0;
    else if (cmd_ion) m_ien = 1;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    drop_cnt += int'(o_kbd_drop);
    cmp("m_inpr", o_inpr, mq.size() != 0 ? mq[0] : 8'h00);
    cmp("m_outr", o_outr, m_outr);
    cmp("m_outr_load", o_outr_load, m_load);
    cmp("m_fgi", o_fgi, mq.size() != 0);
    cmp("m_fgo", o_fgo, !m_busy);
    cmp("m_ien", o_ien, m_ien);
    cmp("m_skip", o_skip, m_skip);
    cmp("m_irq", o_irq, m_irq);
    cmp("m_kbd_drop", o_kbd_drop, m_drop);
    cmp("m_out_err", o_out_err, m_err);
  endtask

  task automatic clr();
    cmd_inp = 0; cmd_out = 0; cmd_ski = 0; cmd_sko = 0; cmd_ion = 0; cmd_iof = 0; int_ack = 0;
  endtask

  task automatic key(input logic [7:0] b);
    kbd_data = b; kbd_flag = 1;
    repeat (4) tick();
    kbd_flag = 0;
    repeat (2) tick();
  endtask

  task automatic pop();
    cmd_inp = 1; tick(); cmd_inp = 0;
  endtask

  initial begin
    int kh = 0, vh = 0;
    tbl[0] = '{1, 0, 0, 1, 0, 1, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 1, 1, 1, 1};
    tbl[2] = '{1, 1, 0, 1, 1, 0, 1, 1};
    tbl[3] = '{1, 0, 0, 0, 0, 1, 0, 0};
    tbl[4] = '{0, 0, 1, 1, 0, 0, 0, 1};
    tbl[5] = '{1, 0, 1, 0, 1, 0, 1, 0};
    tbl[6] = '{1, 0, 0, 0, 0, 1, 0, 0};
    tbl[7] = '{0, 1, 0, 0, 0, 0, 0, 1};
    rst_n = 0; kbd_data = 0; ac_low = 0; kbd_flag = 0; vga_done = 0;
    clr();
    model_reset();
    #12 rst_n = 1;
    #1;
    cmp("rst_fgo", o_fgo, 1); cmp("rst_fgi", o_fgi, 0); cmp("rst_ien", o_ien, 0);
    cmp("rst_inpr", o_inpr, 8'h00); cmp("rst_irq", o_irq, 0); cmp("rst_outr", o_outr, 8'h00);
    // IEN / skip / irq table from the idle, empty state
    foreach (tbl[i]) begin
      cmd_ion = tbl[i].ion != 0; cmd_iof = tbl[i].iof != 0; int_ack = tbl[i].ack != 0;
      cmd_ski = tbl[i].ski != 0; cmd_sko = tbl[i].sko != 0;
      tick();
      clr();
      cmp("tbl_ien", o_ien, 8'(tbl[i].e_ien));
      cmp("tbl_skip", o_skip, 8'(tbl[i].e_skip));
      cmp("tbl_irq", o_irq, 8'(tbl[i].e_irq));
    end
    // single keystroke, three-cycle synchronizer latency
    kbd_data = 8'h41; kbd_flag = 1;
    repeat (2) tick();
    cmp("key_fgi_early", o_fgi, 0);
    tick();
    cmp("key_fgi", o_fgi, 1); cmp("key_inpr", o_inpr, 8'h41);
    kbd_flag = 0;
    pop();
    cmp("inp_fgi", o_fgi, 0); cmp("inp_inpr", o_inpr, 8'h00);
    repeat (2) tick();
    // overflow: fifth byte dropped, first four kept in order
    for (int i = 0; i < 4; i++) key(8'(8'h30 + i));
    drop_cnt = 0;
    key(8'h34);
    cmp("ovf_drop_cnt", 8'(drop_cnt), 8'd1);
    for (int i = 0; i < 4; i++) begin
      cmp("ovf_order", o_inpr, 8'(8'h30 + i));
      pop();
    end
    cmp("ovf_empty", o_fgi, 0);
    // push and pop together while full: no drop
    for (int i = 0; i < 4; i++) key(8'(8'h50 + i));
    kbd_data = 8'h54; kbd_flag = 1;
    repeat (2) tick();
    pop();
    cmp("full_pp_drop", o_kbd_drop, 0); cmp("full_pp_head", o_inpr, 8'h51);
    tick(); kbd_flag = 0; repeat (2) tick();
    for (int i = 1; i < 5; i++) begin
      cmp("full_pp_order", o_inpr, 8'(8'h50 + i));
      pop();
    end
    // push and pop together while empty: pop ignored, push kept
    kbd_data = 8'h60; kbd_flag = 1;
    repeat (2) tick();
    pop();
    cmp("empty_pp_fgi", o_fgi, 1); cmp("empty_pp_inpr", o_inpr, 8'h60);
    tick(); kbd_flag = 0; repeat (2) tick();
    pop();
    // OUT handshake
    ac_low = 8'h5A; cmd_out = 1; tick(); cmd_out = 0;
    cmp("out_outr", o_outr, 8'h5A); cmp("out_load", o_outr_load, 1); cmp("out_fgo", o_fgo, 0);
    ac_low = 8'h11; cmd_out = 1; tick(); cmd_out = 0;
    cmp("out2_err", o_out_err, 1); cmp("out2_outr", o_outr, 8'h5A); cmp("out2_load", o_outr_load, 0);
    vga_done = 1;
    repeat (2) tick();
    cmp("vga_fgo_early", o_fgo, 0);
    tick();
    cmp("vga_fgo", o_fgo, 1);
    vga_done = 0; repeat (2) tick();
    // interrupt request and acknowledge
    cmd_ion = 1; tick(); cmd_ion = 0;
    key(8'h70);
    cmp("irq_set", o_irq, 1);
    int_ack = 1; tick(); int_ack = 0;
    cmp("ack_ien", o_ien, 0);
    tick();
    cmp("ack_irq", o_irq, 0);
    pop();
    // timeout with no vga_done
    ac_low = 8'h22; cmd_out = 1; tick(); cmd_out = 0;
    repeat (TMO - 1) tick();
    cmp("tmo_fgo_early", o_fgo, 0); cmp("tmo_err_early", o_out_err, 0);
    tick();
    cmp("tmo_fgo", o_fgo, 1); cmp("tmo_err", o_out_err, 1);
    // reset in the middle of BUSY with a byte queued
    key(8'h15);
    ac_low = 8'h33; cmd_out = 1; tick(); cmd_out = 0;
    repeat (2) tick();
    #1 rst_n = 0;
    #1;
    cmp("mid_rst_fgo", o_fgo, 1); cmp("mid_rst_fgi", o_fgi, 0);
    cmp("mid_rst_inpr", o_inpr, 8'h00); cmp("mid_rst_outr", o_outr, 8'h00);
    model_reset();
    #2 rst_n = 1;
    // randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      cmd_inp = $urandom_range(0, 3) == 0;
      cmd_out = $urandom_range(0, 5) == 0;
      cmd_ski = $urandom_range(0, 3) == 0;
      cmd_sko = $urandom_range(0, 3) == 0;
      cmd_ion = $urandom_range(0, 7) == 0;
      cmd_iof = $urandom_range(0, 11) == 0;
      int_ack = $urandom_range(0, 11) == 0;
      ac_low = 8'($urandom);
      if (kh == 0) begin
        if ($urandom_range(0, 2) == 0) begin kbd_flag = ~kbd_flag; kh = 4; end
      end else kh--;
      if (!kbd_flag && kh != 4) kbd_data = 8'($urandom);
      if (vh == 0) begin
        if ($urandom_range(0, 3) == 0) begin vga_done = ~vga_done; vh = 4; end
      end else vh--;
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 0;
        #1 model_reset();
        #2 rst_n = 1;
      end
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
